// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial 1011 Moore pattern detector.
// The state encodings are fixed at 0..4 so that 5..7 are the unreachable codes.
package seq_det_pkg;

    typedef enum logic [2:0] {
        ZERO             = 3'd0,
        ONE              = 3'd1,
        ONE_ZERO         = 3'd2,
        ONE_ZERO_ONE     = 3'd3,
        ONE_ZERO_ONE_ONE = 3'd4
    } state_e;

    // Oldest bit in the MSB position, matching a left-shifting history register.
    localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/sequence_detector_moore.sv
// Moore FSM that flags overlapping occurrences of the serial pattern 1011.
// The detect flag is decoded from the state register alone, one cycle per match.
module sequence_detector_moore
    import seq_det_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic sequence_in,
    output logic detector_out
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ZERO;
        end else begin
            state_q <= state_d;
        end
    end

    // On a completed match, the trailing "1" (or the "10" that follows it) is reused.
    always_comb begin
        state_d = ZERO;
        case (state_q)
            ZERO:             state_d = sequence_in ? ONE              : ZERO;
            ONE:              state_d = sequence_in ? ONE              : ONE_ZERO;
            ONE_ZERO:         state_d = sequence_in ? ONE_ZERO_ONE     : ZERO;
            ONE_ZERO_ONE:     state_d = sequence_in ? ONE_ZERO_ONE_ONE : ONE_ZERO;
            ONE_ZERO_ONE_ONE: state_d = sequence_in ? ONE              : ONE_ZERO;
            default:          state_d = ZERO;
        endcase
    end

    always_comb begin
        detector_out = 1'b0;
        if (state_q == ONE_ZERO_ONE_ONE) begin
            detector_out = 1'b1;
        end
    end

endmodule

// File: tb/tb_sequence_detector_moore.sv
// Scoreboard bench for the 1011 detector: every driven bit pushes its expected flag,
// which is popped and compared once the following clock edge has been taken.
module tb_sequence_detector_moore;
    import seq_det_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic sequence_in;
    logic detector_out;

    int vectors     = 0;
    int miscompares = 0;

    logic       expQ[$];
    logic [3:0] hist;

    always #5 clock = ~clock;

    sequence_detector_moore dut (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .detector_out (detector_out)
    );

    // Drives one edge; the expected flag is either given or taken from the history model.
    task automatic driveBit(input logic rst, input logic b, input logic expIn, input logic useModel);
        logic [3:0] nextHist;
        nextHist = rst ? 4'b0000 : {hist[2:0], b};
        reset = rst;
        sequence_in = b;
        expQ.push_back(useModel ? (nextHist == PATTERN) : expIn);
        @(posedge clock);
        #1;
        hist = nextHist;
    endtask

    task automatic resetEdge(input string tag);
        logic exp;
        driveBit(1'b1, 1'b0, 1'b0, 1'b0);
        exp = expQ.pop_front();
        vectors++;
        if (detector_out !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s reset: detector_out=%b expected %b", tag, detector_out, exp);
        end
    endtask

    task automatic test_reset();
        logic exp;
        for (int i = 0; i < 3; i++) resetEdge("reset_hold");
        for (int i = 0; i < 2; i++) begin
            driveBit(1'b0, 1'b0, 1'b0, 1'b0);
            exp = expQ.pop_front();
            vectors++;
            if (detector_out !== exp) begin
                miscompares++;
                $display("[TB] FAIL reset_release %0d: detector_out=%b expected %b", i, detector_out, exp);
            end
        end
    endtask

    task automatic test_basic();
        logic bits [9] = '{1, 0, 1, 1, 0, 0, 1, 1, 0};
        logic exps [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        logic exp;
        resetEdge("basic");
        for (int i = 0; i < 9; i++) begin
            driveBit(1'b0, bits[i], exps[i], 1'b0);
            exp = expQ.pop_front();
            vectors++;
            if (detector_out !== exp) begin
                miscompares++;
                $display("[TB] FAIL basic bit %0d: detector_out=%b expected %b", i, detector_out, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic bits [7] = '{1, 0, 1, 1, 0, 1, 1};
        logic exps [7] = '{0, 0, 0, 1, 0, 0, 1};
        logic exp;
        resetEdge("overlap");
        for (int i = 0; i < 7; i++) begin
            driveBit(1'b0, bits[i], exps[i], 1'b0);
            exp = expQ.pop_front();
            vectors++;
            if (detector_out !== exp) begin
                miscompares++;
                $display("[TB] FAIL overlap bit %0d: detector_out=%b expected %b", i, detector_out, exp);
            end
        end
    endtask

    task automatic test_near_miss();
        logic bits [15] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 1, 0, 1, 1};
        logic exps [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        logic exp;
        resetEdge("near_miss");
        for (int i = 0; i < 15; i++) begin
            driveBit(1'b0, bits[i], exps[i], 1'b0);
            exp = expQ.pop_front();
            vectors++;
            if (detector_out !== exp) begin
                miscompares++;
                $display("[TB] FAIL near_miss bit %0d: detector_out=%b expected %b", i, detector_out, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic rsts [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        logic bits [8] = '{1, 0, 1, 0, 1, 0, 1, 1};
        logic exps [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        logic exp;
        resetEdge("mid_reset");
        for (int i = 0; i < 8; i++) begin
            driveBit(rsts[i], bits[i], exps[i], 1'b0);
            exp = expQ.pop_front();
            vectors++;
            if (detector_out !== exp) begin
                miscompares++;
                $display("[TB] FAIL mid_reset step %0d: detector_out=%b expected %b", i, detector_out, exp);
            end
        end
    endtask

    task automatic test_random();
        logic exp;
        int   hits = 0;
        resetEdge("random");
        for (int i = 0; i < 1000; i++) begin
            driveBit(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            exp = expQ.pop_front();
            vectors++;
            if (exp) hits++;
            if (detector_out !== exp) begin
                miscompares++;
                $display("[TB] FAIL random bit %0d: detector_out=%b expected %b", i, detector_out, exp);
            end
        end
        $display("[TB] random stream produced %0d expected detections", hits);
    endtask

    initial begin
        reset = 1'b1;
        sequence_in = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_back_to_back();
        test_near_miss();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
